serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial N-bit adder controller that time-multiplexes a single shared half_adder instance to compute op_a + op_b, LSB first. Each bit takes two half-adder passes: operand bits first, then partial sum plus running carry. This is the area-minimal adder option for slow control paths. A start/busy/done handshake lets any requester sequence one addition at a time.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 1..32)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
op_a  input  WIDTH  operand A; captured on the accepting edge
op_b  input  WIDTH  operand B; captured on the accepting edge
busy  output  1  high while an addition is in progress (PASS1/PASS2)
done  output  1  one-cycle pulse; sum/cout valid
sum  output  WIDTH  result bits; holds value until the next accepted start
cout  output  1  carry out of bit WIDTH-1; holds like sum

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Datapath: exactly one half_adder instance (X = a^b, Y = a&b). Internal registers:
  - latched operands a_r, b_r
  - bit index idx, width clog2(WIDTH) with a minimum of 1
  - partial sum s1, partial carry c1
  - running carry cy
- Reset (rst=1 at a rising edge): state=IDLE, busy=0, done=0, sum=0, cout=0, idx=0, cy=0. This applies in any state. Reset mid-operation aborts the addition, and no done is produced.
- FSM states: IDLE, PASS1, PASS2, DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1: latch a_r=op_a, b_r=op_b; clear sum=0, cout=0, idx=0, cy=0; go to PASS1.
  - Otherwise stay in IDLE.
- PASS1:
  - Half-adder inputs = a_r[idx], b_r[idx].
  - Register s1=X, c1=Y; go to PASS2.
- PASS2:
  - Half-adder inputs = s1, cy.
  - Write sum[idx]=X; set cy = c1 | Y.
  - If idx==WIDTH-1: set cout = c1 | Y and go to DONE. Otherwise increment idx and go to PASS1.
- DONE:
  - done=1 for exactly this one cycle; go to IDLE.
- Outputs: busy and done are registered and decoded from state. busy=1 only in PASS1/PASS2.
- Latency: if the accepting edge is edge k, done is high between edges k+2*WIDTH and k+2*WIDTH+1. busy is high from edge k to edge k+2*WIDTH.
- Throughput: at most one addition per 2*WIDTH+2 cycles.
- start handling:
  - Ignored in PASS1, PASS2 and DONE; no queuing.
  - start held high continuously restarts the adder on the first IDLE cycle after DONE.
  - op_a/op_b may change freely after the accepting edge without affecting the result.
- Arithmetic: {cout,sum} = op_a + op_b as an unsigned (WIDTH+1)-bit result. No overflow flag beyond cout.
- Intermediate visibility: during busy, sum bits above idx read 0 (cleared at start). Consumers use sum only at or after done.
- WIDTH=1: one PASS1/PASS2 pair; done 2 edges after accept.
- Only the half-adder operand muxes are combinational. All outputs come directly from flops.

Test Plan:
- WIDTH=8, rst high 2 cycles -> busy=0, done=0, sum=0x00, cout=0. start=1 with 0x0F+0x01 -> done exactly 16 edges after accept, sum=0x10, cout=0.
- 0xFF+0x01 -> sum=0x00, cout=1. Then 0xFF+0xFF -> sum=0xFE, cout=1. Then 0x00+0x00 -> sum=0x00, cout=0, with done still asserted.
- start pulsed with 0x11+0x22 at edges k+3 and k+16 of a running 0xA5+0x5A -> both ignored, sum=0xFF, cout=0, exactly one done pulse.
- start held high across two operations (0x01+0x01, then 0x80+0x80) -> second operation accepted on the IDLE cycle after done; results 0x02/cout 0, then 0x00/cout 1; done pulses are 18 edges apart.
- rst asserted at edge k+7 of 0x3C+0xC3 -> next cycle busy=0, sum=0, no done. A subsequent 0x3C+0xC3 gives sum=0xFF, cout=0.
- WIDTH=1 build: 1+1 -> done 2 edges after accept, sum=0, cout=1. 1+0 -> sum=1, cout=0.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared half adder, two passes per bit, LSB first,
// with a start/busy/done handshake. All outputs are driven straight from flops.

module half_adder (
  input  logic a,
  input  logic b,
  output logic x,
  output logic y
);
  assign x = a ^ b;
  assign y = a & b;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

  state_t             state_reg, state_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic [WIDTH-1:0]   a_reg, b_reg, sum_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               s1_reg, c1_reg, cy_reg, cout_reg;
  logic [WIDTH-1:0]   bit_sel, bit_wr;
  logic               accept, last_bit;
  logic               ha_a, ha_b, ha_x, ha_y;

  assign accept   = (state_reg == IDLE) && start;
  assign last_bit = (idx_reg == IDX_W'(WIDTH - 1));

  // One-hot decode of the current bit index; reused for operand select and sum write.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign bit_sel[gi] = (idx_reg == IDX_W'(gi));
    assign bit_wr[gi]  = bit_sel[gi] && (state_reg == PASS2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = PASS1;
      PASS1:   state_next = PASS2;
      PASS2:   state_next = last_bit ? DONE : PASS1;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with the state flops.
  always_comb begin
    busy_next = (state_next == PASS1) || (state_next == PASS2);
    done_next = (state_next == DONE);
  end

  always_comb begin
    ha_a = |(a_reg & bit_sel);
    ha_b = |(b_reg & bit_sel);
    if (state_reg == PASS2) begin
      ha_a = s1_reg;
      ha_b = cy_reg;
    end
  end

  half_adder u_ha (
    .a (ha_a),
    .b (ha_b),
    .x (ha_x),
    .y (ha_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      idx_reg  <= '0;
      s1_reg   <= 1'b0;
      c1_reg   <= 1'b0;
      cy_reg   <= 1'b0;
      cout_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          a_reg    <= op_a;
          b_reg    <= op_b;
          idx_reg  <= '0;
          cy_reg   <= 1'b0;
          cout_reg <= 1'b0;
        end
        PASS1: begin
          s1_reg <= ha_x;
          c1_reg <= ha_y;
        end
        PASS2: begin
          cy_reg <= c1_reg | ha_y;
          if (last_bit) cout_reg <= c1_reg | ha_y;
          else          idx_reg  <= idx_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || accept) sum_reg <= '0;
    else               sum_reg <= (sum_reg & ~bit_wr) | (bit_wr & {WIDTH{ha_x}});
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign sum  = sum_reg;
  assign cout = cout_reg;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: a WIDTH=8 and a WIDTH=1 instance share clk/rst;
// expected sums and done cycles are queued at start and checked on every done pulse.

module tb_serial_adder_ctrl;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] val;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, start, start1;
  logic [7:0] op_a, op_b, sum;
  logic [0:0] op_a1, op_b1, sum1;
  logic       busy, done, cout, busy1, done1, cout1;

  int   cyc = 0;
  int   checks = 0, errors = 0;
  int   done_cnt = 0, done1_cnt = 0;
  exp_t q8[$];
  exp_t q1[$];
  exp_t e8, e1, tmp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .op_a(op_a1), .op_b(op_b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      done_cnt++;
      if (q8.size() == 0) begin
        check("w8_unexpected_done", 1, 0);
      end else begin
        e8 = q8.pop_front();
        $display("w8 add 0x%02h + 0x%02h -> sum 0x%02h cout %0d at cycle %0d",
                 e8.a, e8.b, sum, cout, cyc);
        check("w8_sum", {24'd0, sum}, {24'd0, e8.val[7:0]});
        check("w8_cout", {31'd0, cout}, {31'd0, e8.val[8]});
        check("w8_done_cycle", cyc, e8.cyc);
        check("w8_busy_at_done", {31'd0, busy}, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && done1 === 1'b1) begin
      done1_cnt++;
      if (q1.size() == 0) begin
        check("w1_unexpected_done", 1, 0);
      end else begin
        e1 = q1.pop_front();
        $display("w1 add %0d + %0d -> sum %0d cout %0d at cycle %0d",
                 e1.a[0], e1.b[0], sum1, cout1, cyc);
        check("w1_sum", {31'd0, sum1}, {31'd0, e1.val[0]});
        check("w1_cout", {31'd0, cout1}, {31'd0, e1.val[1]});
        check("w1_done_cycle", cyc, e1.cyc);
      end
    end
  end

  // Called on a negedge while the W8 DUT is idle; returns one negedge after the accepting edge.
  task automatic start_add(input logic [7:0] a, input logic [7:0] b);
    q8.push_back('{a: a, b: b, val: {1'b0, a} + {1'b0, b}, cyc: cyc + 1 + 16});
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(negedge clk);
    start = 1'b0;
    op_a  = 8'($urandom);
    op_b  = 8'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("w8_done_timeout", 0, 1);
  endtask

  task automatic idle_add(input logic [7:0] a, input logic [7:0] b);
    start_add(a, b);
    check("w8_busy_after_accept", {31'd0, busy}, 1);
    wait_done();
    @(negedge clk);
  endtask

  task automatic w1_add(input logic a, input logic b);
    int n = 0;
    q1.push_back('{a: {7'd0, a}, b: {7'd0, b}, val: {8'd0, a} + {8'd0, b}, cyc: cyc + 1 + 2});
    start1 = 1'b1;
    op_a1  = a;
    op_b1  = b;
    @(negedge clk);
    start1 = 1'b0;
    op_a1  = ~a;
    op_b1  = ~b;
    while (done1 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("w1_done_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    int base;
    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    op_a = '0; op_b = '0; op_a1 = '0; op_b1 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_sum", {24'd0, sum}, 0);
    check("rst_cout", {31'd0, cout}, 0);
    rst = 1'b0;
    @(negedge clk);

    idle_add(8'h0F, 8'h01);
    idle_add(8'hFF, 8'h01);
    idle_add(8'hFF, 8'hFF);
    idle_add(8'h00, 8'h00);

    // Stray starts at edges k+3 and k+16 must be ignored.
    base = done_cnt;
    start_add(8'hA5, 8'h5A);
    repeat (2) @(negedge clk);
    start = 1'b1; op_a = 8'h11; op_b = 8'h22;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("stray_start_one_done", done_cnt - base, 1);
    check("stray_start_idle", {31'd0, busy}, 0);

    // start held high: second op accepted on the IDLE cycle right after DONE.
    q8.push_back('{a: 8'h01, b: 8'h01, val: 9'h002, cyc: cyc + 1 + 16});
    start = 1'b1; op_a = 8'h01; op_b = 8'h01;
    @(negedge clk);
    wait_done();
    q8.push_back('{a: 8'h80, b: 8'h80, val: 9'h100, cyc: cyc + 18});
    op_a = 8'h80; op_b = 8'h80;
    repeat (2) @(negedge clk);
    start = 1'b0; op_a = 8'h5C; op_b = 8'hE3;
    check("held_start_busy", {31'd0, busy}, 1);
    wait_done();
    @(negedge clk);

    // Reset in mid-operation aborts without a done pulse.
    start_add(8'h3C, 8'hC3);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_sum", {24'd0, sum}, 0);
    check("abort_cout", {31'd0, cout}, 0);
    tmp = q8.pop_back();
    base = done_cnt;
    repeat (25) @(negedge clk);
    check("abort_no_done", done_cnt - base, 0);
    idle_add(8'h3C, 8'hC3);

    w1_add(1'b1, 1'b1);
    w1_add(1'b1, 1'b0);
    w1_add(1'b0, 1'b0);

    repeat (5) @(negedge clk);
    check("w8_queue_empty", q8.size(), 0);
    check("w1_queue_empty", q1.size(), 0);
    check("w1_done_count", done1_cnt, 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
